// File: rtl/keyboard_scan_receiver.sv
// keyboard_scan_receiver
// Receives PS/2 keyboard frames (start, 8 data LSB first, odd parity, stop),
// folds the 0xE0 / 0xF0 prefix bytes into per-code flags and buffers the
// results in a show-ahead FIFO.
//
// Ports
//   clock50       50 MHz system clock
//   reset         asynchronous active-high reset
//   keyboard_clk  raw PS/2 clock (asynchronous)
//   keyboard_data raw PS/2 data (asynchronous)
//   read          single-cycle pop strobe
//   clear_err     clears the sticky overflow / frame_err flags
//   scan_ready    FIFO not empty
//   scan_code     code at the FIFO head (0 when empty)
//   is_break      head code was preceded by 0xF0
//   is_extended   head code was preceded by 0xE0
//   fifo_count    occupied FIFO entries
//   overflow      sticky: a code was dropped on a full FIFO
//   frame_err     sticky: parity, stop-bit or timeout error
`timescale 1ns/1ps
module keyboard_scan_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock50,
    input  logic                          reset,
    input  logic                          keyboard_clk,
    input  logic                          keyboard_data,
    input  logic                          read,
    input  logic                          clear_err,
    output logic                          scan_ready,
    output logic [7:0]                    scan_code,
    output logic                          is_break,
    output logic                          is_extended,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [CW-1:0]         FULL_C       = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0]         TIMER_LAST_C = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FILTER_LEN-1:0] FILT_ONES_C  = {FILTER_LEN{1'b1}};
    localparam logic [FILTER_LEN-1:0] FILT_ZEROS_C = {FILTER_LEN{1'b0}};

    // Odd parity over data+parity and a high stop bit make a good frame.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return (^{data, par}) & stop;
    endfunction

    logic                  clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic [FILTER_LEN-1:0] filt_r;
    logic                  fclk_r;
    logic                  sample_s;

    logic [1:0]    state_r, state_next_s;
    logic [7:0]    shift_r, shift_next_s;
    logic [2:0]    bit_cnt_r, bit_cnt_next_s;
    logic          parity_r, parity_next_s;
    logic [TW-1:0] timer_r, timer_next_s;
    logic          accept_s, ferr_set_s;

    logic          pend_ext_r, pend_brk_r, pend_ext_next_s, pend_brk_next_s;
    logic          push_s;
    logic [9:0]    push_data_s;

    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [CW-1:0] count_r, count_next_s;
    logic          pop_s, wr_en_s, ovf_set_s;
    logic [9:0]    head_r, head_next_s;
    logic          ready_r;
    logic          ovf_r, ferr_r;

    // Two-flop synchronisers; idle PS/2 lines are high.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= keyboard_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= keyboard_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Glitch filter: the filtered clock only changes after FILTER_LEN equal samples.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            filt_r <= FILT_ONES_C;
            fclk_r <= 1'b1;
        end else begin
            filt_r <= {filt_r[FILTER_LEN-2:0], clk_sync_r};
            if (filt_r == FILT_ONES_C) begin
                fclk_r <= 1'b1;
            end else if (filt_r == FILT_ZEROS_C) begin
                fclk_r <= 1'b0;
            end else begin
                fclk_r <= fclk_r;
            end
        end
    end

    // Sample in the cycle where the filtered clock is about to fall.
    assign sample_s = fclk_r && (filt_r == FILT_ZEROS_C);

    // Frame FSM next-state, bit shifting and idle-timeout detection.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        parity_next_s  = parity_r;
        timer_next_s   = timer_r;
        accept_s       = 1'b0;
        ferr_set_s     = 1'b0;
        if ((state_r != ST_IDLE) && !sample_s && (timer_r == TIMER_LAST_C)) begin
            state_next_s = ST_IDLE;
            timer_next_s = {TW{1'b0}};
            ferr_set_s   = 1'b1;
        end else if (sample_s) begin
            timer_next_s = {TW{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (!data_sync_r) begin
                        state_next_s   = ST_DATA;
                        bit_cnt_next_s = 3'd0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_next_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_next_s = ST_PARITY;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_next_s = data_sync_r;
                    state_next_s  = ST_STOP;
                end
                ST_STOP: begin
                    state_next_s = ST_IDLE;
                    if (frame_ok(shift_r, parity_r, data_sync_r)) begin
                        accept_s = 1'b1;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else if (state_r != ST_IDLE) begin
            timer_next_s = timer_r + TW'(1);
        end else begin
            timer_next_s = {TW{1'b0}};
        end
    end

    // Frame FSM state registers.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            parity_r  <= 1'b0;
            timer_r   <= {TW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            parity_r  <= parity_next_s;
            timer_r   <= timer_next_s;
        end
    end

    // Prefix bytes only arm the pending flags; other bytes are pushed with them.
    always_comb begin
        push_s          = 1'b0;
        push_data_s     = {pend_ext_r, pend_brk_r, shift_r};
        pend_ext_next_s = pend_ext_r;
        pend_brk_next_s = pend_brk_r;
        if (accept_s) begin
            if (shift_r == 8'hE0) begin
                pend_ext_next_s = 1'b1;
            end else if (shift_r == 8'hF0) begin
                pend_brk_next_s = 1'b1;
            end else begin
                push_s          = 1'b1;
                pend_ext_next_s = 1'b0;
                pend_brk_next_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // FIFO control and next head value for the registered show-ahead outputs.
    always_comb begin
        pop_s         = read && (count_r != {CW{1'b0}});
        wr_en_s       = push_s && ((count_r != FULL_C) || pop_s);
        ovf_set_s     = push_s && (count_r == FULL_C) && !pop_s;
        rd_ptr_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        if (wr_en_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!wr_en_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
        // The new head may be the entry being written in this same cycle.
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = 10'h000;
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage; contents are only observed once written.
    always_ff @(posedge clock50) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy, pending prefix flags and output registers.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            pend_ext_r <= 1'b0;
            pend_brk_r <= 1'b0;
            head_r     <= 10'h000;
            ready_r    <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_en_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            pend_ext_r <= pend_ext_next_s;
            pend_brk_r <= pend_brk_next_s;
            head_r     <= head_next_s;
            ready_r    <= (count_next_s != {CW{1'b0}});
        end
    end

    // Sticky error flags; a set in the same cycle as clear_err wins.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            ovf_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clear_err) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (ferr_set_s) begin
                ferr_r <= 1'b1;
            end else if (clear_err) begin
                ferr_r <= 1'b0;
            end else begin
                ferr_r <= ferr_r;
            end
        end
    end

    assign scan_ready  = ready_r;
    assign scan_code   = head_r[7:0];
    assign is_break    = head_r[8];
    assign is_extended = head_r[9];
    assign fifo_count  = count_r;
    assign overflow    = ovf_r;
    assign frame_err   = ferr_r;

endmodule

// File: tb/tb_keyboard_scan_receiver.sv
`timescale 1ns/1ps
module tb_keyboard_scan_receiver;

    localparam int FILTER_LEN     = 8;
    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HB             = 20;   // PS/2 half bit period in clock50 cycles

    logic       clock50 = 1'b0;
    logic       reset = 1'b0;
    logic       keyboard_clk = 1'b1;
    logic       keyboard_data = 1'b1;
    logic       read = 1'b0;
    logic       clear_err = 1'b0;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_extended;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    int tests_run = 0;
    int tests_failed = 0;

    keyboard_scan_receiver #(
        .FILTER_LEN(FILTER_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock50(clock50),
        .reset(reset),
        .keyboard_clk(keyboard_clk),
        .keyboard_data(keyboard_data),
        .read(read),
        .clear_err(clear_err),
        .scan_ready(scan_ready),
        .scan_code(scan_code),
        .is_break(is_break),
        .is_extended(is_extended),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #10 clock50 = ~clock50;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // Send the first nbits of a frame; returns just after the last falling edge.
    task automatic send_bits(input logic [7:0] code, input logic bad_par, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                repeat (HB) @(posedge clock50);
                #1 keyboard_clk = 1'b1;
            end
            repeat (HB / 2) @(posedge clock50);
            #1 keyboard_data = fr[i];
            repeat (HB / 2) @(posedge clock50);
            #1 keyboard_clk = 1'b0;
        end
    endtask

    task automatic release_clk();
        repeat (HB) @(posedge clock50);
        #1 keyboard_clk = 1'b1;
        keyboard_data = 1'b1;
        repeat (HB) @(posedge clock50);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        send_bits(code, bad_par, 1'b1, 11);
        release_clk();
        @(negedge clock50);
    endtask

    task automatic pop();
        @(posedge clock50);
        #1 read = 1'b1;
        @(posedge clock50);
        #1 read = 1'b0;
        @(negedge clock50);
    endtask

    task automatic pulse_clear();
        @(posedge clock50);
        #1 clear_err = 1'b1;
        @(posedge clock50);
        #1 clear_err = 1'b0;
        @(negedge clock50);
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        repeat (3) @(posedge clock50);
        @(negedge clock50);
        tests_run++; if (scan_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%0b exp=0", scan_ready); end
        tests_run++; if (scan_code !== 8'h00) begin tests_failed++; $display("FAIL reset_code got=%h exp=00", scan_code); end
        tests_run++; if ({is_break, is_extended} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got=%b exp=00", {is_break, is_extended}); end
        tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        tests_run++; if ({overflow, frame_err} !== 2'b00) begin tests_failed++; $display("FAIL reset_errs got=%b exp=00", {overflow, frame_err}); end
        @(posedge clock50);
        #1 reset = 1'b0;
        repeat (HB) @(posedge clock50);
    endtask

    task automatic test_single();
        send_bits(8'h1C, 1'b0, 1'b1, 11);
        // 2 sync flops + FILTER_LEN filter stages put the sample 10 edges after the drive.
        repeat (10) @(posedge clock50);
        @(negedge clock50);
        tests_run++; if (scan_ready !== 1'b0) begin tests_failed++; $display("FAIL single_early_ready got=%0b exp=0", scan_ready); end
        @(negedge clock50);
        tests_run++; if (scan_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready got=%0b exp=1", scan_ready); end
        tests_run++; if (scan_code !== 8'h1C) begin tests_failed++; $display("FAIL single_code got=%h exp=1c", scan_code); end
        tests_run++; if ({is_break, is_extended} !== 2'b00) begin tests_failed++; $display("FAIL single_flags got=%b exp=00", {is_break, is_extended}); end
        tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        release_clk();
        pop();
        tests_run++; if ({scan_ready, scan_code, fifo_count} !== 13'd0) begin tests_failed++; $display("FAIL single_pop_empty got ready=%0b code=%h count=%0d exp 0/00/0", scan_ready, scan_code, fifo_count); end
    endtask

    task automatic test_prefix();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL prefix_not_pushed got=%0d exp=0", fifo_count); end
        send_frame(8'h75, 1'b0);
        tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL prefix_count got=%0d exp=1", fifo_count); end
        tests_run++; if (scan_code !== 8'h75) begin tests_failed++; $display("FAIL prefix_code got=%h exp=75", scan_code); end
        tests_run++; if ({is_extended, is_break} !== 2'b11) begin tests_failed++; $display("FAIL prefix_flags got ext/brk=%b exp=11", {is_extended, is_break}); end
        pop();
        send_frame(8'h1C, 1'b0);
        tests_run++; if ({is_extended, is_break, scan_code} !== 10'h01C) begin tests_failed++; $display("FAIL prefix_cleared got=%h exp=01c", {is_extended, is_break, scan_code}); end
        pop();
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1'b1);
        tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL parity_no_push got=%0d exp=0", fifo_count); end
        tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL parity_err got=%0b exp=1", frame_err); end
        pulse_clear();
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL parity_clear got=%0b exp=0", frame_err); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= FIFO_DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0);
        tests_run++; if (fifo_count !== 4'd8) begin tests_failed++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        pulse_clear();
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
        tests_run++; if (scan_code !== 8'h10) begin tests_failed++; $display("FAIL ovf_head got=%h exp=10", scan_code); end
        // Push 0x30 into the full FIFO with a read in the very push cycle.
        send_bits(8'h30, 1'b0, 1'b1, 11);
        repeat (10) @(posedge clock50);
        #1 read = 1'b1;
        @(posedge clock50);
        #1 read = 1'b0;
        @(negedge clock50);
        tests_run++; if ({overflow, fifo_count} !== 5'd8) begin tests_failed++; $display("FAIL full_push_pop got ovf=%0b count=%0d exp 0/8", overflow, fifo_count); end
        release_clk();
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            tests_run++;
            if (scan_code !== ((i == FIFO_DEPTH) ? 8'h30 : 8'h10 + 8'(i))) begin
                tests_failed++; $display("FAIL ovf_order idx=%0d got=%h", i, scan_code);
            end
            pop();
        end
        tests_run++; if ({scan_ready, fifo_count} !== 5'd0) begin tests_failed++; $display("FAIL ovf_drained got ready=%0b count=%0d exp 0/0", scan_ready, fifo_count); end
    endtask

    task automatic test_glitch_timeout();
        keyboard_data = 1'b0;
        @(posedge clock50);
        #1 keyboard_clk = 1'b0;
        repeat (3) @(posedge clock50);
        #1 keyboard_clk = 1'b1;
        repeat (HB) @(posedge clock50);
        keyboard_data = 1'b1;
        @(negedge clock50);
        tests_run++; if (dut.state_r !== 2'd0) begin tests_failed++; $display("FAIL glitch_idle got state=%0d exp=0", dut.state_r); end
        send_bits(8'hA5, 1'b0, 1'b1, 4);
        release_clk();
        repeat (TIMEOUT_CYCLES + 50) @(posedge clock50);
        @(negedge clock50);
        tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err got=%0b exp=1", frame_err); end
        tests_run++; if ({dut.state_r, fifo_count} !== 6'd0) begin tests_failed++; $display("FAIL timeout_idle got state=%0d count=%0d exp 0/0", dut.state_r, fifo_count); end
        pulse_clear();
        send_frame(8'h5A, 1'b0);
        tests_run++; if ({frame_err, fifo_count, scan_code} !== {1'b0, 4'd1, 8'h5A}) begin tests_failed++; $display("FAIL after_timeout got err=%0b count=%0d code=%h exp 0/1/5a", frame_err, fifo_count, scan_code); end
    endtask

    task automatic test_reset_midframe();
        send_bits(8'h66, 1'b0, 1'b1, 5);
        repeat (HB) @(posedge clock50);
        #1 keyboard_clk = 1'b1;
        keyboard_data = 1'b1;
        @(posedge clock50);
        #2 reset = 1'b1;
        #3;
        tests_run++; if ({scan_ready, scan_code, is_break, is_extended, fifo_count, overflow, frame_err} !== 17'd0) begin
            tests_failed++; $display("FAIL async_reset got ready=%0b code=%h count=%0d exp all 0", scan_ready, scan_code, fifo_count);
        end
        @(posedge clock50);
        #1 reset = 1'b0;
        repeat (HB) @(posedge clock50);
        send_frame(8'h29, 1'b0);
        tests_run++; if ({frame_err, fifo_count, scan_code} !== {1'b0, 4'd1, 8'h29}) begin tests_failed++; $display("FAIL after_reset got err=%0b count=%0d code=%h exp 0/1/29", frame_err, fifo_count, scan_code); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity_err();
        test_overflow();
        test_glitch_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
